// File: rtl/int_square_unit.sv
// Iterative shift-add integer squarer: res = in_num * in_num, BITS_PER_CYCLE
// multiplier bits per cycle, finishing as soon as the remaining multiplier is zero.
module int_square_unit #(
    parameter int SIZE           = 32,
    parameter int BITS_PER_CYCLE = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   in_num,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] res
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [SIZE-1:0]   opnd;
    logic [SIZE-1:0]   mult;
    logic [SIZE-1:0]   mult_next;
    logic [2*SIZE-1:0] acc;
    logic [2*SIZE-1:0] acc_next;
    logic [CW-1:0]     chunk;

    // Partial product of one chunk: low BITS_PER_CYCLE bits of the already
    // shifted multiplier, weighted by the chunk's bit position.
    function automatic logic [2*SIZE-1:0] chunk_sum(
        input logic [SIZE-1:0] op,
        input logic [SIZE-1:0] m,
        input logic [CW-1:0]   c
    );
        logic [2*SIZE-1:0] ext;
        logic [2*SIZE-1:0] sum;
        int                base;
        ext  = {{SIZE{1'b0}}, op};
        sum  = '0;
        base = int'(c) * BITS_PER_CYCLE;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (m[i]) sum = sum + (ext << (base + i));
        end
        return sum;
    endfunction

    assign mult_next = mult >> BITS_PER_CYCLE;
    assign acc_next  = acc + chunk_sum(opnd, mult, chunk);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            opnd  <= '0;
            mult  <= '0;
            acc   <= '0;
            chunk <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd  <= in_num;
                        mult  <= in_num;
                        acc   <= '0;
                        chunk <= '0;
                        busy  <= 1'b1;
                        if (in_num == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            res   <= '0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mult  <= mult_next;
                    chunk <= chunk + CW'(1);
                    if (mult_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        res   <= acc_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_square_unit.sv
// Directed-vector bench for int_square_unit: result values, done latency,
// busy/done framing, ignored start while busy and abort by reset.
module tb_int_square_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] in_num;
    logic        busy;
    logic        done;
    logic [63:0] res;

    int checks   = 0;
    int failures = 0;

    int_square_unit #(.SIZE(32), .BITS_PER_CYCLE(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in_num (in_num),
        .busy   (busy),
        .done   (done),
        .res    (res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle. Issues start for one cycle,
    // optionally re-pulses start (with in_num=5) in cycle T+inj, then waits for
    // done, checks its cycle and the result, and returns at the following
    // idle negedge.
    task automatic run_op(input string tag, input logic [31:0] val,
                          input logic [63:0] exp_res, input int exp_lat, input int inj);
        int lat;
        start  = 1'b1;
        in_num = val;
        @(negedge clk);
        start  = 1'b0;
        in_num = 32'hDEAD_BEEF;
        lat    = 1;
        check({tag, "_busy_t1"}, {63'd0, busy}, 64'd1);
        while (!done && lat < 20) begin
            if (inj != 0 && lat == inj) begin
                start  = 1'b1;
                in_num = 32'd5;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, res, exp_res);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_res_hold"}, res, exp_res);
    endtask

    initial begin
        int seen_done;
        rst    = 1'b0;
        start  = 1'b0;
        in_num = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_res", res, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("sq3",      32'd3,          64'd9,                  2, 0);
        run_op("sq0",      32'd0,          64'd0,                  1, 0);
        run_op("sq46341",  32'h0000_B505,  64'h0000_0000_8000_1219, 4, 0);
        run_op("sq63",     32'd63,         64'd3969,               2, 0);
        run_op("sq64",     32'd64,         64'd4096,               3, 0);
        run_op("sq4095",   32'h0000_0FFF,  64'd16769025,           3, 0);
        run_op("sqmax",    32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 7, 0);
        run_op("sq2_b2b",  32'd2,          64'd4,                  2, 0);
        run_op("sqmax_ig", 32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 7, 3);

        // Abort by reset during CALC
        start  = 1'b1;
        in_num = 32'hFFFF_FFFF;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_res", res, 64'd0);
        rst = 1'b1;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_res_hold", res, 64'd0);
        run_op("sq7", 32'd7, 64'd49, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
